job_dispatcher: RTL and testbench



---
 rtl/job_dispatch_pkg.sv | 23 ++
 rtl/dispatch_timer.sv | 27 ++
 rtl/job_dispatcher.sv | 114 +++++++++++
 tb/tb_job_dispatcher.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/job_dispatch_pkg.sv
// Shared encodings for the job dispatcher and the three-phase worker it drives.
package job_dispatch_pkg;

  localparam int unsigned WK_W = 2;
  localparam int unsigned ST_W = 3;

  typedef logic [WK_W-1:0] wk_state_t;
  typedef logic [ST_W-1:0] disp_state_t;

  localparam wk_state_t WK_IDLE = 2'b00;
  localparam wk_state_t WK_LOAD = 2'b01;
  localparam wk_state_t WK_DONE = 2'b10;
  localparam wk_state_t WK_BAD  = 2'b11;

  localparam disp_state_t D_IDLE      = 3'd0;
  localparam disp_state_t D_ISSUE     = 3'd1;
  localparam disp_state_t D_WAIT_LOAD = 3'd2;
  localparam disp_state_t D_WAIT_DONE = 3'd3;
  localparam disp_state_t D_WAIT_IDLE = 3'd4;
  localparam disp_state_t D_COMPLETE  = 3'd5;
  localparam disp_state_t D_ERROR     = 3'd6;

endpackage

// File: rtl/dispatch_timer.sv
// Wait-state watchdog: counts while run is held, drops to zero otherwise.
module dispatch_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  output logic expire_c
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (run) begin
      count <= count + TW'(1);
    end else begin
      count <= '0;
    end
  end

  assign expire_c = (count == TW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/job_dispatcher.sv
// Batch dispatcher: issues one start per job to a three-phase worker and
// follows it IDLE -> LOAD -> DONE -> IDLE, with a sticky stall/illegal-state error.
module job_dispatcher
  import job_dispatch_pkg::*;
#(
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  input  logic [CNT_W-1:0] req_count,
  output logic             req_ready,
  input  logic [1:0]       worker_state,
  output logic             start,
  output logic             busy,
  output logic             done_pulse,
  output logic [CNT_W-1:0] jobs_done,
  output logic             timeout_err,
  input  logic             clear_err
);

  disp_state_t      state, next_state;
  logic [CNT_W-1:0] remaining, remaining_nxt, jobs_nxt;
  logic             in_wait, wait_hit;
  logic             tmr_run, tmr_expire;

  dispatch_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .run      (tmr_run),
    .expire_c (tmr_expire)
  );

  // State, counters and pulse outputs; outputs are set from next_state so they line up with state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= D_IDLE;
      remaining   <= '0;
      jobs_done   <= '0;
      start       <= 1'b0;
      busy        <= 1'b0;
      done_pulse  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= next_state;
      remaining   <= remaining_nxt;
      jobs_done   <= jobs_nxt;
      start       <= (next_state == D_ISSUE);
      busy        <= (next_state != D_IDLE) && (next_state != D_ERROR);
      done_pulse  <= (next_state == D_COMPLETE);
      timeout_err <= (next_state == D_ERROR);
    end
  end

  always_comb begin
    next_state    = state;
    remaining_nxt = remaining;
    jobs_nxt      = jobs_done;
    in_wait       = 1'b0;
    wait_hit      = 1'b0;

    case (state)
      D_IDLE: begin
        if (req_valid) begin
          if (req_count == '0) begin
            next_state = D_COMPLETE;
          end else begin
            remaining_nxt = req_count;
            next_state    = D_ISSUE;
          end
        end
      end
      D_ISSUE: next_state = D_WAIT_LOAD;
      D_WAIT_LOAD: begin
        in_wait  = 1'b1;
        wait_hit = (worker_state == WK_LOAD);
        if (wait_hit) next_state = D_WAIT_DONE;
      end
      D_WAIT_DONE: begin
        in_wait  = 1'b1;
        wait_hit = (worker_state == WK_DONE);
        if (wait_hit) begin
          jobs_nxt      = jobs_done + CNT_W'(1);
          remaining_nxt = remaining - CNT_W'(1);
          next_state    = (remaining == CNT_W'(1)) ? D_COMPLETE : D_WAIT_IDLE;
        end
      end
      D_WAIT_IDLE: begin
        in_wait  = 1'b1;
        wait_hit = (worker_state == WK_IDLE);
        if (wait_hit) next_state = D_ISSUE;
      end
      D_COMPLETE: next_state = D_IDLE;
      D_ERROR: begin
        if (clear_err) next_state = D_IDLE;
      end
      default: next_state = D_IDLE;
    endcase

    // Progress beats expiry; an illegal worker code never counts as progress.
    if (in_wait && !wait_hit && ((worker_state == WK_BAD) || tmr_expire)) begin
      next_state = D_ERROR;
    end
    if (next_state == D_ERROR) remaining_nxt = '0;

    tmr_run = in_wait && (next_state == state);
  end

  assign req_ready = (state == D_IDLE);

endmodule

// File: tb/tb_job_dispatcher.sv
// Randomized bench for job_dispatcher with a scripted worker and a behavioural reference model.
module tb_job_dispatcher;
  import job_dispatch_pkg::*;

  localparam int unsigned CNT_W = 8;
  localparam int TMO = 16;
  localparam int MODE_IDEAL = 0, MODE_RAND = 1, MODE_STALL = 2,
                 MODE_BAD_LOAD = 3, MODE_BAD_DONE = 4, MODE_LOAD5 = 5;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             req_valid;
  logic [CNT_W-1:0] req_count;
  logic             req_ready;
  logic [1:0]       worker_state;
  logic             start, busy, done_pulse, timeout_err, clear_err;
  logic [CNT_W-1:0] jobs_done;

  job_dispatcher #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_count(req_count),
    .req_ready(req_ready), .worker_state(worker_state), .start(start), .busy(busy),
    .done_pulse(done_pulse), .jobs_done(jobs_done), .timeout_err(timeout_err),
    .clear_err(clear_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0, cyc = 0;

  // Reference model: what the dispatcher is doing in the current cycle.
  bit m_ready, m_issue, m_complete, m_err;
  int m_await, m_left, m_waited, m_jobs;

  logic [1:0] wk_q[$];
  int wk_mode;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_ready = 1; m_issue = 0; m_complete = 0; m_err = 0;
    m_await = -1; m_left = 0; m_waited = 0; m_jobs = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit nr, ni, nc, ne;
    int na;
    nr = 0; ni = 0; nc = 0; ne = m_err; na = -1;
    if (m_err) begin
      if (clear_err) begin ne = 0; nr = 1; end
    end else if (m_ready) begin
      if (req_valid) begin
        if (req_count == 0) nc = 1;
        else begin m_left = int'(req_count); ni = 1; end
      end else nr = 1;
    end else if (m_issue) begin
      na = 1; m_waited = 0;
    end else if (m_complete) begin
      nr = 1;
    end else begin
      if (worker_state == 2'b11) begin ne = 1; m_left = 0; end
      else if (int'(worker_state) == m_await) begin
        m_waited = 0;
        if (m_await == 1) na = 2;
        else if (m_await == 2) begin
          m_jobs = (m_jobs + 1) % (1 << CNT_W);
          m_left--;
          if (m_left == 0) nc = 1; else na = 0;
        end else ni = 1;
      end
      else if (m_waited == TMO - 1) begin ne = 1; m_left = 0; end
      else begin m_waited++; na = m_await; end
    end
    m_ready = nr; m_issue = ni; m_complete = nc; m_err = ne; m_await = na;
  endtask

  task automatic compare();
    chk("start",       int'(start),       int'(m_issue));
    chk("done_pulse",  int'(done_pulse),  int'(m_complete));
    chk("timeout_err", int'(timeout_err), int'(m_err));
    chk("req_ready",   int'(req_ready),   int'(m_ready));
    chk("busy",        int'(busy),        int'(!m_ready && !m_err));
    chk("jobs_done",   int'(jobs_done),   m_jobs);
  endtask

  // Worker reaction to a start pulse, queued as per-cycle state values.
  task automatic push_job();
    int a, b, c;
    case (wk_mode)
      MODE_IDEAL: begin wk_q.push_back(WK_LOAD); wk_q.push_back(WK_DONE); end
      MODE_RAND: begin
        a = $urandom_range(0, 3); b = $urandom_range(1, 4); c = $urandom_range(1, 3);
        repeat (a) wk_q.push_back(WK_IDLE);
        repeat (b) wk_q.push_back(WK_LOAD);
        repeat (c) wk_q.push_back(WK_DONE);
      end
      MODE_BAD_LOAD: wk_q.push_back(WK_BAD);
      MODE_BAD_DONE: begin wk_q.push_back(WK_LOAD); wk_q.push_back(WK_BAD); end
      MODE_LOAD5: begin repeat (5) wk_q.push_back(WK_LOAD); wk_q.push_back(WK_DONE); end
      default: ;
    endcase
  endtask

  task automatic cycle();
    logic [1:0] w;
    w = (wk_q.size() > 0) ? wk_q.pop_front() : WK_IDLE;
    if (start === 1'b1) push_job();
    worker_state = w;
    model_step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    compare();
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!(m_ready && wk_q.size() == 0) && k < 200) begin cycle(); k++; end
    if (k >= 200) chk("wait_ready_budget", 0, 1);
  endtask

  task automatic run_batch(input int count, input int mode, input bit noise,
                           output int done_off, output int n_start, output int first_start,
                           output int last_start, output int err_off);
    int k;
    bit fin;
    k = 0; fin = 0;
    done_off = -1; n_start = 0; first_start = -1; last_start = -1; err_off = -1;
    wk_mode = mode;
    req_valid = 1'b1; req_count = CNT_W'(count);
    while (!fin && k < 1200) begin
      cycle();
      k++;
      req_valid = 1'b0;
      if (noise && k == 2) begin req_valid = 1'b1; req_count = CNT_W'(5); end
      if (start) begin n_start++; if (first_start < 0) first_start = k; last_start = k; end
      if (done_pulse && done_off < 0) done_off = k;
      if (timeout_err && err_off < 0) err_off = k;
      if (m_ready || m_err) fin = 1;
    end
    req_valid = 1'b0;
    if (!fin) chk("batch_budget", 0, 1);
  endtask

  task automatic clear_error();
    clear_err = 1'b1;
    cycle();
    clear_err = 1'b0;
    wk_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d, ns, fs, ls, eo, k, r;
    bit fin;
    reset_n = 1'b1; req_valid = 1'b0; req_count = '0; worker_state = WK_IDLE; clear_err = 1'b0;
    wk_mode = MODE_IDEAL;
    model_reset();
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", int'(req_ready), 1);
    chk("rst_start", int'(start), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_jobs", int'(jobs_done), 0);
    chk("rst_err", int'(timeout_err), 0);
    reset_n = 1'b1;
    cycle();

    // Directed: ideal single job, 3-job batch with ignored request, zero batch.
    run_batch(1, MODE_IDEAL, 0, d, ns, fs, ls, eo);
    chk("single_done_cycle", d, 4);
    chk("single_starts", ns, 1);
    chk("single_jobs", int'(jobs_done), 1);
    chk("single_ready_back", int'(req_ready), 1);
    wait_ready();
    run_batch(3, MODE_IDEAL, 1, d, ns, fs, ls, eo);
    chk("batch3_starts", ns, 3);
    chk("batch3_first_start", fs, 1);
    chk("batch3_last_start", ls, 9);
    chk("batch3_done_cycle", d, 12);
    chk("batch3_jobs", int'(jobs_done), 4);
    wait_ready();
    run_batch(0, MODE_IDEAL, 0, d, ns, fs, ls, eo);
    chk("zero_done_cycle", d, 1);
    chk("zero_starts", ns, 0);
    chk("zero_jobs", int'(jobs_done), 4);

    // Directed: stall timeout, clear, illegal worker state, short LOAD stall.
    wait_ready();
    run_batch(2, MODE_STALL, 0, d, ns, fs, ls, eo);
    chk("stall_err_cycle", eo, 18);
    chk("stall_starts", ns, 1);
    chk("stall_busy", int'(busy), 0);
    clear_error();
    chk("clear_err_flag", int'(timeout_err), 0);
    chk("clear_ready", int'(req_ready), 1);
    wait_ready();
    run_batch(1, MODE_BAD_DONE, 0, d, ns, fs, ls, eo);
    chk("bad_err_cycle", eo, 4);
    chk("bad_jobs", int'(jobs_done), 4);
    clear_error();
    wait_ready();
    run_batch(1, MODE_LOAD5, 0, d, ns, fs, ls, eo);
    chk("load5_done_cycle", d, 8);
    chk("load5_no_err", eo, -1);
    chk("load5_jobs", int'(jobs_done), 5);

    // Randomized batches with worker jitter, fault injection and input noise.
    for (int b = 0; b < 40; b++) begin
      wait_ready();
      r = $urandom_range(0, 9);
      wk_mode = (r == 0) ? MODE_STALL : (r == 1) ? MODE_BAD_DONE :
                (r == 2) ? MODE_BAD_LOAD : MODE_RAND;
      req_valid = 1'b1;
      req_count = CNT_W'($urandom_range(0, 6));
      clear_err = 1'($urandom_range(0, 1));
      k = 0; fin = 0;
      while (!fin && k < 600) begin
        cycle();
        k++;
        req_valid = 1'b0; clear_err = 1'b0;
        if (m_err) clear_err = ($urandom_range(0, 3) == 0);
        else if (!m_ready) begin
          req_valid = ($urandom_range(0, 3) == 0);
          req_count = CNT_W'($urandom_range(0, 255));
          clear_err = ($urandom_range(0, 3) == 0);
        end else fin = 1;
      end
      req_valid = 1'b0; clear_err = 1'b0;
      if (!fin) chk("rand_budget", 0, 1);
    end

    // Asynchronous reset while the worker is mid-job.
    wait_ready();
    wk_mode = MODE_IDEAL;
    req_valid = 1'b1; req_count = CNT_W'(3);
    cycle();
    req_valid = 1'b0;
    k = 0;
    while (m_await != 2 && k < 50) begin cycle(); k++; end
    chk("reach_wait_done", m_await, 2);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_start", int'(start), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_ready", int'(req_ready), 1);
    chk("async_rst_jobs", int'(jobs_done), 0);
    chk("async_rst_err", int'(timeout_err), 0);
    wk_q.delete();
    worker_state = WK_IDLE;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    cycle();

    // Completion counter wrap: 255 + 3 jobs.
    run_batch(255, MODE_IDEAL, 0, d, ns, fs, ls, eo);
    chk("big_done_cycle", d, 1020);
    chk("big_jobs", int'(jobs_done), 255);
    wait_ready();
    run_batch(3, MODE_IDEAL, 0, d, ns, fs, ls, eo);
    chk("wrap_jobs", int'(jobs_done), 2);
    repeat (3) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
